// File: rtl/sdram_arbiter_pkg.sv
// rtl/sdram_arbiter_pkg.sv - shared types and default widths for the SDRAM port arbiter
package sdram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_ACK   = 2'd1,
        WAIT_VALID = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_PORTS  = 4;
    localparam int DEF_ADDR_WIDTH = 23;
    localparam int DEF_DATA_WIDTH = 32;

endpackage

// File: rtl/sdram_arbiter_rr_select.sv
// rtl/sdram_arbiter_rr_select.sv - combinational round-robin picker starting after the last served port
module rr_select #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_WIDTH = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_WIDTH-1:0] last,
    output logic                 any,
    output logic [IDX_WIDTH-1:0] winner
);

    // Scan from lowest to highest priority so the closest requester after last wins.
    always_comb begin
        int idx;
        any    = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_PORTS;
            if (req[idx]) begin
                any    = 1'b1;
                winner = idx[IDX_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - round-robin sharing of one SDRAM controller port between several requesters
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int NUM_PORTS  = DEF_NUM_PORTS,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_data,
    input  logic [NUM_PORTS-1:0]            port_we,
    input  logic [NUM_PORTS-1:0]            port_req,
    output logic [NUM_PORTS-1:0]            port_ack,
    output logic [NUM_PORTS-1:0]            port_valid,
    output logic [DATA_WIDTH-1:0]           port_q,
    output logic [ADDR_WIDTH-1:0]           sdram_addr,
    output logic [DATA_WIDTH-1:0]           sdram_data,
    output logic                            sdram_we,
    output logic                            sdram_req,
    input  logic                            sdram_ack,
    input  logic                            sdram_valid,
    input  logic [DATA_WIDTH-1:0]           sdram_q,
    output logic                            busy
);

    localparam int IW = $clog2(NUM_PORTS);

    arb_state_e             state_q, state_d;
    logic [IW-1:0]          owner_q, owner_d;
    logic [IW-1:0]          last_q, last_d;
    logic                   req_q, req_d;
    logic                   we_q, we_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;

    logic                   rr_any;
    logic [IW-1:0]          rr_winner;

    rr_select #(
        .NUM_PORTS(NUM_PORTS),
        .IDX_WIDTH(IW)
    ) u_rr_select (
        .req    (port_req),
        .last   (last_q),
        .any    (rr_any),
        .winner (rr_winner)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (rr_any) begin
                    owner_d = rr_winner;
                    addr_d  = port_addr[int'(rr_winner)*ADDR_WIDTH +: ADDR_WIDTH];
                    data_d  = port_data[int'(rr_winner)*DATA_WIDTH +: DATA_WIDTH];
                    we_d    = port_we[rr_winner];
                    req_d   = 1'b1;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (sdram_ack) begin
                    req_d   = 1'b0;
                    last_d  = owner_q;
                    state_d = we_q ? IDLE : WAIT_VALID;
                end
            end
            WAIT_VALID: begin
                if (sdram_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IW'(NUM_PORTS - 1);
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Pulses are gated by state so stray controller strobes never reach a port.
    always_comb begin
        port_ack   = '0;
        port_valid = '0;
        if (state_q == WAIT_ACK && sdram_ack) begin
            port_ack[owner_q] = 1'b1;
        end
        if (state_q == WAIT_VALID && sdram_valid) begin
            port_valid[owner_q] = 1'b1;
        end
    end

    assign port_q     = sdram_q;
    assign sdram_addr = addr_q;
    assign sdram_data = data_q;
    assign sdram_we   = we_q;
    assign sdram_req  = req_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - self-checking bench for sdram_arbiter with a transaction-level reference model
module tb_sdram_arbiter;

    localparam int N  = 4;
    localparam int AW = 23;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N*AW-1:0] port_addr;
    logic [N*DW-1:0] port_data;
    logic [N-1:0]    port_we;
    logic [N-1:0]    port_req;
    logic [N-1:0]    port_ack;
    logic [N-1:0]    port_valid;
    logic [DW-1:0]   port_q;
    logic [AW-1:0]   sdram_addr;
    logic [DW-1:0]   sdram_data;
    logic            sdram_we;
    logic            sdram_req;
    logic            sdram_ack;
    logic            sdram_valid;
    logic [DW-1:0]   sdram_q;
    logic            busy;

    always #5 clk = ~clk;

    sdram_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .port_addr(port_addr), .port_data(port_data), .port_we(port_we), .port_req(port_req),
        .port_ack(port_ack), .port_valid(port_valid), .port_q(port_q),
        .sdram_addr(sdram_addr), .sdram_data(sdram_data), .sdram_we(sdram_we), .sdram_req(sdram_req),
        .sdram_ack(sdram_ack), .sdram_valid(sdram_valid), .sdram_q(sdram_q), .busy(busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference: an access is either absent, waiting for acceptance, or waiting for read data.
    bit            m_active;
    bit            m_accepted;
    int            m_owner;
    int            m_last;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    bit            m_we;
    int            grants[$];

    logic [N-1:0]  seen_ack;
    int            ctl_phase;
    int            ctl_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active   = 0;
        m_accepted = 0;
        m_owner    = 0;
        m_last     = N - 1;
        m_addr     = '0;
        m_data     = '0;
        m_we       = 0;
    endtask

    task automatic model_check();
        logic [N-1:0] exp_ack;
        logic [N-1:0] exp_valid;
        if (reset) model_reset();
        exp_ack   = '0;
        exp_valid = '0;
        if (m_active && !m_accepted && sdram_ack)  exp_ack[m_owner]   = 1'b1;
        if (m_active && m_accepted && sdram_valid) exp_valid[m_owner] = 1'b1;
        chk("sdram_req", sdram_req, m_active && !m_accepted);
        chk("sdram_addr", sdram_addr, m_addr);
        chk("sdram_data", sdram_data, m_data);
        chk("sdram_we", sdram_we, m_we);
        chk("busy", busy, m_active);
        chk("port_ack", port_ack, exp_ack);
        chk("port_valid", port_valid, exp_valid);
        chk("port_q", port_q, sdram_q);
        seen_ack = port_ack;
        if (!reset) begin
            if (!m_active) begin
                for (int k = 1; k <= N; k++) begin
                    int p;
                    p = (m_last + k) % N;
                    if (!m_active && port_req[p]) begin
                        m_active   = 1;
                        m_accepted = 0;
                        m_owner    = p;
                        m_addr     = port_addr[p*AW +: AW];
                        m_data     = port_data[p*DW +: DW];
                        m_we       = port_we[p];
                    end
                end
            end else if (!m_accepted) begin
                if (sdram_ack) begin
                    grants.push_back(m_owner);
                    m_last     = m_owner;
                    m_accepted = 1;
                    if (m_we) m_active = 0;
                end
            end else if (sdram_valid) begin
                m_active = 0;
            end
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
        model_check();
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
        sdram_ack   = 1'b0;
        sdram_valid = 1'b0;
    endtask

    task automatic adv(input int n);
        repeat (n) begin
            to_neg();
            to_drive();
        end
    endtask

    task automatic set_port(input int p, input bit r, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        port_req[p]         = r;
        port_we[p]          = we;
        port_addr[p*AW +: AW] = a;
        port_data[p*DW +: DW] = d;
    endtask

    task automatic ctl_step(input bit spur);
        if (ctl_phase == 0) begin
            if (sdram_req) begin
                ctl_phase = 1;
                ctl_cnt   = $urandom_range(0, 2);
            end else if (spur && $urandom_range(0, 7) == 0) begin
                sdram_valid = 1'b1;
                sdram_q     = $urandom;
            end
        end
        if (ctl_phase == 1) begin
            if (ctl_cnt == 0) begin
                sdram_ack = 1'b1;
                ctl_phase = sdram_we ? 0 : 2;
                ctl_cnt   = $urandom_range(1, 3);
            end else begin
                ctl_cnt--;
            end
        end else if (ctl_phase == 2) begin
            if (ctl_cnt == 0) begin
                sdram_valid = 1'b1;
                sdram_q     = $urandom;
                ctl_phase   = 0;
            end else begin
                ctl_cnt--;
                if (spur && $urandom_range(0, 3) == 0) sdram_ack = 1'b1;
            end
        end
    endtask

    initial begin
        int exp_order[6];
        exp_order = '{0, 1, 2, 3, 0, 1};
        port_addr = '0; port_data = '0; port_we = '0; port_req = '0;
        sdram_ack = 0; sdram_valid = 0; sdram_q = '0;
        ctl_phase = 0; ctl_cnt = 0; seen_ack = '0;
        model_reset();

        to_neg();
        chk("rst_req", sdram_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ack", port_ack, 0);
        to_drive();
        reset = 1'b0;

        // Single read from port 2
        set_port(2, 1, 0, 23'h012345, 32'h0);
        to_neg(); chk("t1_req_c0", sdram_req, 0); to_drive();
        to_neg(); chk("t1_req_c1", sdram_req, 1); chk("t1_addr", sdram_addr, 23'h012345); chk("t1_we", sdram_we, 0);
        to_drive();
        adv(2);
        sdram_ack = 1'b1;
        to_neg(); chk("t1_ack", port_ack, 4'b0100); to_drive();
        port_req[2] = 1'b0;
        adv(4);
        sdram_valid = 1'b1; sdram_q = 32'hDEADBEEF;
        to_neg(); chk("t1_valid", port_valid, 4'b0100); chk("t1_q", port_q, 32'hDEADBEEF); to_drive();
        to_neg(); chk("t1_busy", busy, 0); to_drive();

        // Port 0 write, then port 1 read that drops its request after the grant
        set_port(0, 1, 1, 23'h000100, 32'hA5A5A5A5);
        set_port(1, 1, 0, 23'h000200, 32'h0);
        to_neg(); to_drive();
        to_neg(); chk("t3_we", sdram_we, 1); chk("t3_data", sdram_data, 32'hA5A5A5A5); to_drive();
        adv(1);
        sdram_ack = 1'b1;
        to_neg(); chk("t3_ack", port_ack, 4'b0001); chk("t3_novalid", port_valid, 0); to_drive();
        port_req[0] = 1'b0;
        to_neg(); chk("t3_req_c4", sdram_req, 0); chk("t3_busy_c4", busy, 0); to_drive();
        to_neg(); chk("t3_req_c5", sdram_req, 1); chk("t3_addr_c5", sdram_addr, 23'h000200); to_drive();
        port_req[1] = 1'b0;
        to_neg(); chk("t4_req_held", sdram_req, 1); to_drive();
        sdram_ack = 1'b1;
        to_neg(); chk("t4_ack", port_ack, 4'b0010); to_drive();
        adv(1);
        sdram_valid = 1'b1; sdram_q = 32'h12345678;
        to_neg(); chk("t4_valid", port_valid, 4'b0010); to_drive();

        // Spurious strobes, then reset in the middle of a read
        sdram_valid = 1'b1; sdram_q = 32'h0BADF00D;
        to_neg(); chk("t5_idle_valid", port_valid, 0); chk("t5_idle_busy", busy, 0); to_drive();
        set_port(1, 1, 0, 23'h000300, 32'h0);
        to_neg(); to_drive();
        sdram_ack = 1'b1;
        to_neg(); chk("t5_ack", port_ack, 4'b0010); to_drive();
        port_req[1] = 1'b0;
        sdram_ack = 1'b1;
        to_neg(); chk("t5_extra_ack", port_ack, 0); chk("t5_busy", busy, 1); to_drive();
        reset = 1'b1;
        set_port(0, 1, 0, 23'h000400, 32'h0);
        set_port(2, 1, 0, 23'h000500, 32'h0);
        to_neg(); chk("t6_req", sdram_req, 0); chk("t6_busy", busy, 0); chk("t6_addr", sdram_addr, 0); to_drive();
        reset = 1'b0;
        sdram_valid = 1'b1;
        to_neg(); chk("t6_late_valid", port_valid, 0); to_drive();
        to_neg(); chk("t6_first_grant", sdram_addr, 23'h000400); chk("t6_first_req", sdram_req, 1); to_drive();

        // All four ports reading continuously
        reset = 1'b1;
        for (int p = 0; p < N; p++) set_port(p, 1, 0, AW'(p * 16 + 1), 32'h0);
        to_neg(); to_drive();
        reset = 1'b0;
        ctl_phase = 0;
        grants.delete();
        for (int c = 0; c < 300 && grants.size() < 6; c++) begin
            ctl_step(0);
            to_neg();
            to_drive();
        end
        chk("t2_grant_count", grants.size() >= 6, 1);
        for (int i = 0; i < 6; i++) chk($sformatf("t2_grant%0d", i), (i < grants.size()) ? grants[i] : -1, exp_order[i]);

        // Randomized traffic with spurious strobes and occasional resets
        port_req = '0;
        reset = 1'b1;
        to_neg(); to_drive();
        reset = 1'b0;
        ctl_phase = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b1;
                ctl_phase = 0;
            end else begin
                reset = 1'b0;
            end
            for (int p = 0; p < N; p++) begin
                if (port_req[p] && seen_ack[p]) port_req[p] = 1'b0;
                else if (!port_req[p] && $urandom_range(0, 3) == 0)
                    set_port(p, 1, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
            end
            ctl_step(1);
            to_neg();
            to_drive();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
